// File: rtl/add_operand_sequencer.sv
// add_operand_sequencer
// Upstream feeder for the two-operand registered adder stage. Operand pairs
// arrive over a valid/ready handshake into a small FIFO. Each pair leaves as a
// single-cycle start pulse with registered a/b, with a programmable minimum
// idle spacing between pulses. A 2-bit shift register follows each start
// through the adder's 2-cycle latency so that busy covers results still in
// flight.
module add_operand_sequencer #(
  parameter int W     = 8,   // operand width, matches the adder
  parameter int DEPTH = 4,   // FIFO entries, power of two, >= 2
  parameter int GAP   = 0,   // idle cycles forced after each start pulse
  parameter int CW    = 16   // width of the issued-operation counter
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic                     issue_en,
  input  logic                     flush,
  output logic                     start,
  output logic [W-1:0]             a,
  output logic [W-1:0]             b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic [CW-1:0]            issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  // A GAP of zero still needs a one-bit counter that simply stays at zero.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP);

  // FIFO storage, kept as two parallel arrays indexed by the same pointers
  logic [W-1:0]  mem_a [DEPTH];
  logic [W-1:0]  mem_b [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    inflight;

  logic          push;
  logic          pop;

  // Handshake, issue decision and status, all derived from registered state
  always_comb begin
    in_ready = (count != FULL_COUNT);
    push     = in_valid && in_ready && !flush;
    // Pop looks at registered occupancy, so a pair pushed into an empty FIFO
    // cannot leave on the same edge it is accepted.
    pop      = (count != '0) && issue_en && (gap_cnt == '0) && !flush;
    busy     = (count != '0) | start | (|inflight);
  end

  // FIFO data write; storage needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue and drops any push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue stage: start pulse, registered operands and issue counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start      <= 1'b0;
      a          <= '0;
      b          <= '0;
      issued_cnt <= '0;
    end else if (pop) begin
      start      <= 1'b1;
      a          <= mem_a[rd_ptr];
      b          <= mem_b[rd_ptr];
      issued_cnt <= issued_cnt + CW'(1);
    end else begin
      start      <= 1'b0;
    end
  end

  // Spacing counter: reloads on issue, otherwise runs down regardless of
  // issue_en or flush so a stall never stretches the enforced gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (pop) begin
      gap_cnt <= GAP_RELOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // In-flight tracker covering the adder's 2-cycle latency after each start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight <= {inflight[0], start};
    end
  end

endmodule
